uart_sim_rx: RTL and testbench

- Serial UART receiver, 8N1 format: 8 data bits, no parity, 1 stop bit, LSB first, line idles high.
- Sits beside the processor wrapper in simulation and system benches. It decodes the processor's UART TX line into bytes.
- Each received byte is presented on a parallel output with a one-cycle valid strobe.
- In simulation it also prints each received character to the console.

---
 rtl/uart_sim_rx.sv | 130 +++++++++++++
 tb/tb_uart_sim_rx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sim_rx.sv
// 8N1 UART receiver for simulation benches: decodes a TX line into bytes
// with a one-cycle valid strobe, optionally echoing characters to the console.
module uart_sim_rx #(
   parameter int unsigned CLOCK_FREQ = 100000000,
   parameter int unsigned BAUD_RATE  = 19200
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       txd_i,
   output logic [7:0] data_o,
   output logic       valid_o
);

   localparam int unsigned BAUD = CLOCK_FREQ / BAUD_RATE;
   localparam logic [31:0] C_BAUD = 32'(BAUD);
   localparam logic [31:0] C_HALF = 32'(BAUD / 2);

   if (BAUD < 4) begin : g_baud_check
      $fatal(1, "uart_sim_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t      r_state;
   logic [1:0]  r_sync;
   logic [31:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic [7:0]  r_data;
   logic        r_valid;

   logic        w_rxs;
   logic [31:0] w_cnt_dec;
   logic        w_tick;

   assign w_rxs     = r_sync[1];
   assign w_cnt_dec = r_cnt - 32'd1;
   // Acting on the 1->0 step gives a sample period of exactly BAUD cycles.
   assign w_tick    = (w_cnt_dec == 32'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], txd_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 32'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  r_cnt   <= C_HALF;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_cnt <= w_cnt_dec;
               if (w_tick) begin
                  if (!w_rxs) begin
                     r_cnt   <= C_BAUD;
                     r_bit   <= 3'd0;
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               r_cnt <= w_cnt_dec;
               if (w_tick) begin
                  r_shift <= {w_rxs, r_shift[7:1]};
                  r_cnt   <= C_BAUD;
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               r_cnt <= w_cnt_dec;
               if (w_tick) begin
                  if (w_rxs) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_BRK;
                  end
               end
            end
            S_BRK: begin
               if (w_rxs) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;

`ifdef SIMULATION
   always @(posedge clk_i) begin
      if (r_valid) begin
         $write("%c", r_data);
      end
   end
`endif

endmodule

// File: tb/tb_uart_sim_rx.sv
// Bench for uart_sim_rx: a fast instance (BAUD=10) and one at default rates,
// checked against byte queues built from the 8N1 framing rules.
module tb_uart_sim_rx;

   localparam int BT   = 100;
   localparam int BT_D = 52080;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       txd = 1'b1;
   logic       txd_d = 1'b1;
   logic [7:0] data;
   logic [7:0] data_d;
   logic       valid;
   logic       valid_d;

   int checks = 0;
   int errors = 0;

   byte unsigned got_q[$];
   longint       got_t[$];
   byte unsigned got_d[$];
   byte unsigned exp_q[$];

   always #5 clk = ~clk;

   uart_sim_rx #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) u_fast (
      .clk_i  (clk),
      .rst_i  (rst),
      .txd_i  (txd),
      .data_o (data),
      .valid_o(valid)
   );

   uart_sim_rx u_dflt (
      .clk_i  (clk),
      .rst_i  (rst),
      .txd_i  (txd_d),
      .data_o (data_d),
      .valid_o(valid_d)
   );

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         got_q.push_back(data);
         got_t.push_back($time);
      end
      if (valid_d === 1'b1) begin
         got_d.push_back(data_d);
      end
   end

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clk);
      #3;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) txd_d = v;
      else txd = v;
   endtask

   // Reference model: a frame yields its byte only if the stop bit is high.
   task automatic send_frame(input bit sel, input logic [7:0] b,
                             input int bt, input logic stop);
      drive(sel, 1'b0);
      #(bt);
      for (int i = 0; i < 8; i++) begin
         drive(sel, b[i]);
         #(bt);
      end
      drive(sel, stop);
      #(bt);
      if (!sel && stop) exp_q.push_back(b);
   endtask

   task automatic clear_q();
      got_q.delete();
      got_t.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %02h expected 00", data);
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", valid);
      end
      checks++;
      if (data_d !== 8'h00 || valid_d !== 1'b0) begin
         errors++;
         $display("FAIL reset_dflt: got %02h/%b expected 00/0", data_d, valid_d);
      end
      rst = 1'b0;
      idle(30);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL reset_idle_strobes: got %0d expected 0", got_q.size());
      end
   endtask

   task automatic test_single();
      longint t0;
      longint lat;
      clear_q();
      t0 = $time;
      send_frame(0, 8'h4E, BT, 1'b1);
      idle(5);
      checks++;
      if (got_q.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d expected 1", got_q.size());
      end
      checks++;
      if (got_q.size() > 0 && got_q[0] != exp_q[0]) begin
         errors++;
         $display("FAIL single_data: got %02h expected %02h", got_q[0], exp_q[0]);
      end
      if (got_t.size() > 0) begin
         lat = (got_t[0] - 5 - t0) / 10;
         checks++;
         if (lat < 95 || lat > 99) begin
            errors++;
            $display("FAIL single_latency: got %0d expected 97 +-2", lat);
         end
      end
      checks++;
      if (data !== 8'h4E) begin
         errors++;
         $display("FAIL single_hold: got %02h expected 4e", data);
      end
   endtask

   task automatic test_stream();
      byte unsigned msg[$];
      msg = '{8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32};
      for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
      clear_q();
      foreach (msg[i]) send_frame(0, msg[i], BT, 1'b1);
      idle(5);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL stream_count: got %0d expected %0d",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] != exp_q[i]) begin
            errors++;
            $display("FAIL stream_byte%0d: got %02h expected %02h",
                     i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_glitch();
      int g;
      g = $urandom_range(1, 4);
      clear_q();
      txd = 1'b0;
      #(g * 10);
      txd = 1'b1;
      idle(25);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_strobe: got %0d expected 0 (len %0d)",
                  got_q.size(), g);
      end
      send_frame(0, 8'hA5, BT, 1'b1);
      idle(5);
      checks++;
      if (got_q.size() != 1 || got_q[0] != 8'hA5) begin
         errors++;
         $display("FAIL glitch_next: got %0d strobes data %02h expected 1 a5",
                  got_q.size(), data);
      end
   endtask

   task automatic test_framing();
      clear_q();
      send_frame(0, 8'h55, BT, 1'b0);
      #(30 * 10);
      txd = 1'b1;
      idle(20);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL framing_strobe: got %0d expected 0", got_q.size());
      end
      checks++;
      if (data !== 8'hA5) begin
         errors++;
         $display("FAIL framing_hold: got %02h expected a5", data);
      end
      send_frame(0, 8'h3C, BT, 1'b1);
      idle(5);
      checks++;
      if (got_q.size() != 1 || data !== 8'h3C) begin
         errors++;
         $display("FAIL framing_next: got %0d strobes data %02h expected 1 3c",
                  got_q.size(), data);
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      fork
         send_frame(0, 8'hFF, BT, 1'b1);
         begin
            #(BT * 5 + BT / 2);
            rst = 1'b1;
            #1;
            checks++;
            if (data !== 8'h00 || valid !== 1'b0) begin
               errors++;
               $display("FAIL rstmid_outputs: got %02h/%b expected 00/0",
                        data, valid);
            end
         end
      join
      exp_q.delete();
      idle(2);
      rst = 1'b0;
      idle(105);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL rstmid_strobe: got %0d expected 0", got_q.size());
      end
      send_frame(0, 8'h81, BT, 1'b1);
      idle(5);
      checks++;
      if (got_q.size() != 1 || data !== 8'h81) begin
         errors++;
         $display("FAIL rstmid_next: got %0d strobes data %02h expected 1 81",
                  got_q.size(), data);
      end
   endtask

   task automatic test_skew();
      int bts[2];
      bts = '{102, 98};
      foreach (bts[k]) begin
         clear_q();
         send_frame(0, 8'h96, bts[k], 1'b1);
         send_frame(0, 8'h69, bts[k], 1'b1);
         send_frame(0, 8'($urandom), bts[k], 1'b1);
         idle(15);
         checks++;
         if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL skew%0d_count: got %0d expected %0d",
                     bts[k], got_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
               errors++;
               $display("FAIL skew%0d_byte%0d: got %02h expected %02h",
                        bts[k], i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_default();
      byte unsigned b;
      b = 8'($urandom);
      got_d.delete();
      send_frame(1, b, BT_D, 1'b1);
      idle(10);
      checks++;
      if (got_d.size() != 1) begin
         errors++;
         $display("FAIL dflt_count: got %0d expected 1", got_d.size());
      end
      checks++;
      if (data_d !== b) begin
         errors++;
         $display("FAIL dflt_data: got %02h expected %02h", data_d, b);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_glitch();
      test_framing();
      test_reset_mid();
      test_skew();
      test_default();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
